// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and funct3 decode helpers for the M-extension unit
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return op == OP_MULH || op == OP_DIV || op == OP_REM;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring divide on {hi,lo}
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi_n,
   output logic [XLEN-1:0] lo_n
);

   logic [XLEN:0] sum, sh, diff;
   logic          ok;

   // multiply: add multiplicand on lo[0], shift {carry,hi,lo} right; divide: trial-subtract shifted remainder
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      sh   = {hi, lo[XLEN-1]};
      diff = sh - {1'b0, b};
      ok   = ~diff[XLEN];
      hi_n = div ? (ok ? diff[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
      lo_n = div ? {lo[XLEN-2:0], ok} : {sum[0], lo[XLEN-1:1]};
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide; optional MDU_EARLY_OUT_EN ends multiplies once the multiplier is exhausted
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   state_t              state;
   logic [2:0]          op;
   logic [CNT_W-1:0]    cnt;
   logic                neg;
   logic [XLEN-1:0]     hi, lo, b, hi_n, lo_n;
   logic                sa, sb, dz, ovf, mz, special, exit_calc;
   logic [XLEN-1:0]     ma, mb, sp_res, qr, fix_res;
   logic [2*XLEN-1:0]   prod, prod_n;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div  (is_div(op)),
      .hi   (hi),
      .lo   (lo),
      .b    (b),
      .hi_n (hi_n),
      .lo_n (lo_n)
   );

   // operand magnitudes, special-case detection and the final sign/half selection
   always_comb begin
      sa      = is_signed_a(funct3) & srcA[XLEN-1];
      sb      = is_signed_b(funct3) & srcB[XLEN-1];
      ma      = sa ? -srcA : srcA;
      mb      = sb ? -srcB : srcB;
      dz      = is_div(funct3) && srcB == '0;
      ovf     = is_div(funct3) && is_signed_a(funct3) && srcA == {1'b1, {(XLEN-1){1'b0}}} && srcB == '1;
`ifdef MDU_EARLY_OUT_EN
      mz      = !is_div(funct3) && srcB == '0;
      exit_calc = cnt == CNT_W'(1) || (!is_div(op) && (lo_n & ~({XLEN{1'b1}} << (cnt - CNT_W'(1)))) == '0);
`else
      mz      = 1'b0;
      exit_calc = cnt == CNT_W'(1);
`endif
      special = dz || ovf || mz;
      sp_res  = dz ? (funct3[1] ? srcA : '1) : ovf ? (funct3[1] ? '0 : srcA) : '0;
      prod    = {hi, lo};
`ifdef MDU_EARLY_OUT_EN
      prod    = prod >> cnt;
`endif
      prod_n  = neg ? -prod : prod;
      qr      = op[1] ? hi : lo;
      fix_res = is_div(op) ? (neg ? -qr : qr) : (op == OP_MUL ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN]);
   end

   // control FSM with registered busy/done/result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         op     <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         b      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op  <= funct3;
               neg <= (is_div(funct3) && funct3[1]) ? sa : sa ^ sb;
               hi  <= '0;
               lo  <= is_div(funct3) ? ma : mb;
               b   <= is_div(funct3) ? mb : ma;
               cnt <= CNT_W'(XLEN);
               if (special) begin
                  result <= sp_res;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  busy  <= 1'b1;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               hi  <= hi_n;
               lo  <= lo_n;
               cnt <= cnt - CNT_W'(1);
               if (exit_calc) state <= S_FIX;
            end
            S_FIX: begin
               result <= fix_res;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results, latency and handshake checks
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        busy, done;
   logic [31:0] result;
   int          tests = 0;
   int          fails = 0;
   int          seen, d1, d2;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .funct3  (funct3),
      .srcA    (srcA),
      .srcB    (srcB),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] bb,
                      input logic [31:0] exp, input int exp_lat);
      int lat = 0;
      int bcnt = 0;
      @(negedge clk);
      funct3 = f; srcA = a; srcB = bb; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; funct3 = ~f; srcA = ~a; srcB = ~bb;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         if (done) lat = k;
         else begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
         end
      end
      chk({tag, "_res"}, result, exp);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busy"}, bcnt, exp_lat - 1);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'b0, done}, 0);
   endtask

   initial begin
      #1;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_result", result, 0);
      #20 reset_n = 1'b1;

      run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
      run("mulhn",  3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34);
      run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
      run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
      run("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
      run("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34);

      // reset mid-operation
      @(negedge clk);
      funct3 = 3'b100; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_res", result, 0);
      @(negedge clk) reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("abort_nodone", seen, 0);
      run("post_rst", 3'b101, 32'd100, 32'd7, 32'd14, 34);

      run("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
      run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // start pulses while busy are ignored
      @(negedge clk);
      funct3 = 3'b011; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; srcA = 32'd5; srcB = 32'd7;
      seen = 0;
      for (int k = 1; k <= 80; k++) begin
         if (done) seen++;
         start = (k == 5 || k == 20);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("busy_start_dones", seen, 1);
      chk("busy_start_res", result, 32'hFFFFFFFE);

      // start held high: back-to-back ops with one idle cycle between
      @(negedge clk);
      funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      d1 = 0; d2 = 0;
      for (int k = 1; k <= 80; k++) begin
         if (done) begin
            if (d1 == 0) d1 = k;
            else if (d2 == 0) d2 = k;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("held_first", d1, 34);
      chk("held_second", d2, 69);
      chk("held_res", result, 32'd14);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
